// File: rtl/dma_stream_source_if.sv
// rtl/dma_stream_source_if.sv - stream handshake bundle between the pattern source and the DMA S2MM port
interface dma_stream_source_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/dma_stream_source.sv
// rtl/dma_stream_source.sv - register-controlled test-pattern stream source for benchmarking the DMA write path
module dma_stream_source #(
  parameter int          LEN_W     = 16,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          ctrl,
  input  logic [31:0]          length,
  input  logic [31:0]          seed,
  dma_stream_source_if.master  m,
  output logic [31:0]          status,
  output logic [31:0]          beat_count,
  output logic [31:0]          frame_count,
  output logic [31:0]          stall_count,
  output logic [7:0]           led
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic             ctrl0_q;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       mode_q;
  logic [31:0]      data;
  logic             abort_pending;
  logic             done, aborted, len_err;

  logic             start_edge, len_zero, in_run, last_beat, hs, last_hs;
  logic [31:0]      init_data, rem_ext;
  logic             unused_bits;

  function automatic logic [31:0] next_data(input logic [1:0] md, input logic [31:0] d);
    case (md)
      2'd0:    return d + 32'd1;
      2'd1:    return (d >> 1) ^ (d[0] ? LFSR_POLY : 32'h0);
      2'd2:    return d;
      default: return {d[30:0], d[31]};
    endcase
  endfunction

  assign start_edge = ctrl[0] & ~ctrl0_q;
  assign len_zero   = (length[LEN_W-1:0] == '0);
  assign in_run     = (state == RUN);
  assign last_beat  = in_run & ((remaining == LEN_W'(1)) | abort_pending);
  assign hs         = in_run & m.tready;
  assign last_hs    = hs & last_beat;

  // An all-zero LFSR state would lock up, so mode 1 substitutes 1 for a zero seed.
  always_comb begin
    init_data = seed;
    case (ctrl[3:2])
      2'd1:    init_data = (seed == 32'h0) ? 32'h1 : seed;
      2'd3:    init_data = 32'h1;
      default: init_data = seed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    m.tvalid = in_run;
    m.tlast  = last_beat;
    m.tdata  = data;
    case (state)
      IDLE, DONE: if (start_edge) state_n = len_zero ? IDLE : RUN;
      RUN:        if (last_hs && (abort_pending || !ctrl[4] || len_zero)) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl0_q       <= 1'b0;
      remaining     <= '0;
      mode_q        <= 2'd0;
      data          <= 32'h0;
      abort_pending <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      len_err       <= 1'b0;
      beat_count    <= 32'h0;
      frame_count   <= 32'h0;
      stall_count   <= 32'h0;
    end else begin
      ctrl0_q <= ctrl[0];
      if (!in_run && start_edge) begin
        done <= 1'b0;
        if (len_zero) begin
          len_err <= 1'b1;
        end else begin
          remaining     <= length[LEN_W-1:0];
          mode_q        <= ctrl[3:2];
          data          <= init_data;
          beat_count    <= 32'h0;
          stall_count   <= 32'h0;
          aborted       <= 1'b0;
          len_err       <= 1'b0;
          abort_pending <= 1'b0;
        end
      end else if (in_run) begin
        if (ctrl[1]) abort_pending <= 1'b1;
        if (!m.tready) stall_count <= stall_count + 32'd1;
        if (hs) begin
          beat_count <= beat_count + 32'd1;
          remaining  <= remaining - LEN_W'(1);
          data       <= next_data(mode_q, data);
          if (last_beat) begin
            frame_count <= frame_count + 32'd1;
            done        <= 1'b1;
            if (abort_pending) begin
              aborted       <= 1'b1;
              abort_pending <= 1'b0;
            end else if (ctrl[4] && !len_zero) begin
              remaining <= length[LEN_W-1:0];
            end
          end
        end
      end
    end
  end

  assign rem_ext     = 32'(remaining);
  assign status      = {rem_ext[15:0], 12'h0, len_err, aborted, done, in_run};
  assign led         = {frame_count[3:0], len_err, aborted, done, in_run};
  assign unused_bits = ^{ctrl[31:5], length[31:LEN_W], rem_ext[31:16]};

endmodule

// File: tb/tb_dma_stream_source.sv
// tb/tb_dma_stream_source.sv - directed scoreboard bench for dma_stream_source
module tb_dma_stream_source;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl, length, seed;
  logic [31:0] status, beat_count, frame_count, stall_count;
  logic [7:0]  led;
  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       q[$];

  dma_stream_source_if m_if ();

  dma_stream_source dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl),
    .length      (length),
    .seed        (seed),
    .m           (m_if),
    .status      (status),
    .beat_count  (beat_count),
    .frame_count (frame_count),
    .stall_count (stall_count),
    .led         (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    q.push_back(b);
  endtask

  // Drive tready, score any handshake about to happen, then step to #1 past the next edge.
  task automatic cycle(input logic rdy);
    beat_t b;
    m_if.tready = rdy;
    if (m_if.tvalid && rdy) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", m_if.tdata, 32'hx);
      end else begin
        b = q.pop_front();
        chk("tdata", m_if.tdata, b.data);
        chk("tlast", {31'h0, m_if.tlast}, {31'h0, b.last});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept n beats back to back; tvalid must stay high throughout (no bubbles).
  task automatic drain(input int n);
    int got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      chk("tvalid_run", {31'h0, m_if.tvalid}, 32'h1);
      if (m_if.tvalid) got++;
      cycle(1'b1);
    end
    chk("drain_count", got, n);
  endtask

  task automatic start(input logic [31:0] c, input logic [31:0] len, input logic [31:0] sd);
    length = len;
    seed   = sd;
    ctrl   = c;
    chk("tvalid_before_start", {31'h0, m_if.tvalid}, 32'h0);
    cycle(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl = 32'h0; length = 32'h0; seed = 32'h0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'h0, m_if.tvalid}, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_frames", frame_count, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    rst_n = 1'b1;
    cycle(1'b1);

    // mode 0 incrementing frame
    for (int i = 0; i < 4; i++) push(32'h10 + i, i == 3);
    start(32'h1, 32'd4, 32'h10);
    drain(4);
    ctrl = 32'h0;
    cycle(1'b1);
    chk("m0_tvalid_after", {31'h0, m_if.tvalid}, 32'h0);
    chk("m0_beats", beat_count, 32'd4);
    chk("m0_frames", frame_count, 32'd1);
    chk("m0_status", status, 32'h00000002);
    chk("m0_led", {24'h0, led}, 32'h12);

    // same frame with a three-cycle stall on the second beat
    for (int i = 0; i < 4; i++) push(32'h10 + i, i == 3);
    start(32'h1, 32'd4, 32'h10);
    cycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_tdata", m_if.tdata, 32'h11);
      chk("stall_tvalid", {31'h0, m_if.tvalid}, 32'h1);
      cycle(1'b0);
    end
    drain(3);
    ctrl = 32'h0;
    cycle(1'b1);
    chk("stall_count", stall_count, 32'd3);
    chk("stall_beats", beat_count, 32'd4);

    // mode 1 LFSR, zero seed replaced by 1
    push(32'h00000001, 1'b0);
    push(32'h80200003, 1'b0);
    push(32'hC0300002, 1'b1);
    start(32'h5, 32'd3, 32'h0);
    drain(3);
    ctrl = 32'h0;
    cycle(1'b1);
    chk("lfsr_led", {24'h0, led}, 32'h32);

    // abort while beat 5 is stalled
    for (int i = 0; i < 4; i++) push(i, 1'b0);
    push(32'd4, 1'b1);
    start(32'h1, 32'd100, 32'h0);
    drain(4);
    ctrl = 32'h2;
    chk("abort_held0", m_if.tdata, 32'd4);
    cycle(1'b0);
    ctrl = 32'h0;
    chk("abort_held1", m_if.tdata, 32'd4);
    chk("abort_tlast", {31'h0, m_if.tlast}, 32'h1);
    drain(1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_tvalid", {31'h0, m_if.tvalid}, 32'h0);
      cycle(1'b1);
    end
    chk("abort_status", status, 32'h005F0006);
    chk("abort_beats", beat_count, 32'd5);
    chk("abort_frames", frame_count, 32'd4);

    // zero length start reports an error and never streams
    start(32'h1, 32'd0, 32'h0);
    ctrl = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_no_tvalid", {31'h0, m_if.tvalid}, 32'h0);
      cycle(1'b1);
    end
    chk("len0_len_err", {31'h0, status[3]}, 32'h1);
    chk("len0_done_clr", {31'h0, status[1]}, 32'h0);
    chk("len0_led3", {31'h0, led[3]}, 32'h1);
    push(32'h7, 1'b1);
    start(32'h1, 32'd1, 32'h7);
    drain(1);
    ctrl = 32'h0;
    cycle(1'b1);
    chk("len0_recover_status", status, 32'h00000002);
    chk("len0_recover_frames", frame_count, 32'd5);

    // continuous mode across the 32-bit wrap
    push(32'hFFFFFFFE, 1'b0);
    push(32'hFFFFFFFF, 1'b1);
    push(32'h0, 1'b0);
    push(32'h1, 1'b1);
    push(32'h2, 1'b0);
    push(32'h3, 1'b1);
    start(32'h11, 32'd2, 32'hFFFFFFFE);
    drain(2);
    chk("cont_frames1", frame_count, 32'd6);
    drain(4);
    chk("cont_frames3", frame_count, 32'd8);
    chk("cont_still_run", {31'h0, m_if.tvalid}, 32'h1);
    ctrl = 32'h10;
    m_if.tready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", {31'h0, m_if.tvalid}, 32'h0);
    chk("rst_mid_tlast", {31'h0, m_if.tlast}, 32'h0);
    chk("rst_mid_tdata", m_if.tdata, 32'h0);
    chk("rst_mid_status", status, 32'h0);
    chk("rst_mid_counts", beat_count | frame_count | stall_count, 32'h0);
    chk("rst_mid_led", {24'h0, led}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
